// File: rtl/pipeline_pkg.sv
// Shared types for the branch controller: instruction classes, opcode
// constants, pipeline metadata and the 2-bit counter update rule.
package pipeline_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_BR   = 2'd1,
    CLS_JAL  = 2'd2,
    CLS_JALR = 2'd3
  } br_class_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    br_class_e   cls;
    logic        pred_taken;
    logic [31:0] pred_target;
  } br_meta_t;

  // Map instr[6:2] onto a control-flow class.
  function automatic br_class_e decode_class(input logic [4:0] op);
    br_class_e cls;
    case (op)
      OP_BRANCH: cls = CLS_BR;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      default:   cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  // Saturating 2-bit counter step (0..3).
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters. Combinational read,
// synchronous update; reset puts every entry at weakly not-taken. A read of
// the index being written in the same cycle returns the old value.
module bht_2bit
  import pipeline_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] r_ctr      [ENTRIES];
  logic [1:0] w_ctr_next [ENTRIES];

  // Per-entry next value: only the addressed entry moves on a write.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign w_ctr_next[gi] = (wr_en_i && (wr_idx_i == IDX_W'(gi)))
                              ? ctr_update(r_ctr[gi], wr_taken_i)
                              : r_ctr[gi];
    end
  endgenerate

  // Counter array state: reset to weakly not-taken, else take next values.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst_i) begin
        r_ctr[i] <= 2'b01;
      end else begin
        r_ctr[i] <= w_ctr_next[i];
      end
    end
  end

  assign rd_ctr_o = r_ctr[rd_idx_i];

endmodule

// File: rtl/branch_ctrl_pipeline.sv
// Branch prediction and redirect controller for a 5-stage RV32I pipeline.
// IF predicts B-type via the BHT and JAL as always taken; the prediction is
// carried through ID to EX, where it is checked against the resolved outcome
// and a one-cycle flush/redirect is raised on a mispredict.
module branch_ctrl_pipeline
  import pipeline_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_instr_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_br_sel_i,
  input  logic [31:0] ex_target_i,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  br_meta_t    r_id;
  br_meta_t    r_ex;
  logic [31:0] r_br_cnt;
  logic [31:0] r_mispred_cnt;

  br_class_e   w_if_cls;
  logic [31:0] w_b_imm;
  logic [31:0] w_j_imm;
  logic [1:0]  w_bht_ctr;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;
  br_meta_t    w_if_meta;

  logic        w_resolve;
  logic        w_taken;
  logic        w_mispredict;
  logic [31:0] w_ex_pc_plus4;
  logic        w_bht_wr;
  logic        w_unused;

  // Low opcode bits are always 2'b11 for RV32I and carry no information here.
  assign w_unused = ^if_instr_i[1:0];

  // IF decode: class and sign-extended B/J immediates.
  assign w_if_cls = if_valid_i ? decode_class(if_instr_i[6:2]) : CLS_NONE;
  assign w_b_imm  = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                     if_instr_i[30:25], if_instr_i[11:8], 1'b0};
  assign w_j_imm  = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                     if_instr_i[20], if_instr_i[30:21], 1'b0};

  // IF prediction: BHT MSB for branches, always taken for JAL, else fall-through.
  always_comb begin
    w_pred_taken  = 1'b0;
    w_pred_target = if_pc_i + 32'd4;
    case (w_if_cls)
      CLS_BR: begin
        w_pred_taken  = w_bht_ctr[1];
        w_pred_target = if_pc_i + w_b_imm;
      end
      CLS_JAL: begin
        w_pred_taken  = 1'b1;
        w_pred_target = if_pc_i + w_j_imm;
      end
      default: ;
    endcase
  end

  assign pred_taken_o  = w_pred_taken;
  assign pred_target_o = w_pred_target;

  // Bundle the IF prediction into the metadata record handed to ID.
  always_comb begin
    w_if_meta             = '0;
    w_if_meta.valid       = if_valid_i;
    w_if_meta.pc          = if_pc_i;
    w_if_meta.cls         = w_if_cls;
    w_if_meta.pred_taken  = w_pred_taken;
    w_if_meta.pred_target = w_pred_target;
  end

  // Metadata pipe IF->ID->EX; flush wins over stall, stall holds both stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id <= '0;
      r_ex <= '0;
    end else if (flush_o) begin
      r_id.valid <= 1'b0;
      r_ex.valid <= 1'b0;
    end else if (!stall_i) begin
      r_id <= w_if_meta;
      r_ex <= r_id;
    end
  end

  // EX resolution: compare actual outcome with the carried prediction.
  always_comb begin
    w_ex_pc_plus4 = r_ex.pc + 32'd4;
    w_resolve     = r_ex.valid && !stall_i;
    w_taken       = (r_ex.cls != CLS_NONE) && ex_br_sel_i;
    w_mispredict  = w_resolve &&
                    ((w_taken != r_ex.pred_taken) ||
                     (w_taken && (ex_target_i != r_ex.pred_target)));
    w_bht_wr      = w_resolve && (r_ex.cls == CLS_BR);
  end

  assign flush_o       = w_mispredict;
  assign redirect_o    = w_mispredict;
  assign redirect_pc_o = (w_mispredict && w_taken) ? ex_target_i : w_ex_pc_plus4;

  // Performance counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_bht_wr) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_mispredict) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign br_cnt_o      = r_br_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (if_pc_i[IDX_W+1:2]),
    .rd_ctr_o   (w_bht_ctr),
    .wr_en_i    (w_bht_wr),
    .wr_idx_i   (r_ex.pc[IDX_W+1:2]),
    .wr_taken_i (w_taken)
  );

endmodule

// File: tb/tb_branch_ctrl_pipeline.sv
// Self-checking bench for branch_ctrl_pipeline: table of single-instruction
// transactions checked through a scoreboard, plus hand-written stall and
// mid-flight reset sequences.
module tb_branch_ctrl_pipeline;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [31:0] if_instr_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_br_sel_i;
  logic [31:0] ex_target_i;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mispred_cnt_o;

  branch_ctrl_pipeline dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .if_valid_i    (if_valid_i),
    .if_pc_i       (if_pc_i),
    .if_instr_i    (if_instr_i),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .ex_br_sel_i   (ex_br_sel_i),
    .ex_target_i   (ex_target_i),
    .flush_o       (flush_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .br_cnt_o      (br_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        br_sel;
    logic [31:0] ex_tgt;
    logic        is_br;
    logic        exp_pred;
    logic [31:0] exp_tgt;
    logic        exp_flush;
    logic [31:0] exp_rpc;
  } vec_t;

  typedef struct {
    int          id;
    logic        valid;
    logic        flush;
    logic [31:0] rpc;
  } sb_t;

  localparam int NV = 12;
  vec_t        vecs [NV];
  sb_t         sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  m_bht [16];
  logic [31:0] m_br  = 0;
  logic [31:0] m_mis = 0;

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic bs, input logic [31:0] et, input logic isb,
                              input logic ep, input logic [31:0] etg, input logic ef,
                              input logic [31:0] er);
    vec_t r;
    r.valid = v; r.pc = pc; r.instr = ins; r.br_sel = bs; r.ex_tgt = et; r.is_br = isb;
    r.exp_pred = ep; r.exp_tgt = etg; r.exp_flush = ef; r.exp_rpc = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, " br_cnt"}, br_cnt_o, m_br);
    check({tag, " mispred_cnt"}, mispred_cnt_o, m_mis);
    for (int i = 0; i < 16; i++) begin
      check({tag, $sformatf(" bht[%0d]", i)}, {30'd0, dut.u_bht.r_ctr[i]}, {30'd0, m_bht[i]});
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    sb_t e;
    sb_t got;
    if_valid_i = v.valid; if_pc_i = v.pc; if_instr_i = v.instr;
    ex_br_sel_i = 1'b0; ex_target_i = 32'd0;
    @(negedge clk);
    check($sformatf("v%0d pred_taken", id), {31'd0, pred_taken_o}, {31'd0, v.exp_pred});
    check($sformatf("v%0d pred_target", id), pred_target_o, v.exp_tgt);
    e.id = id; e.valid = v.valid; e.flush = v.exp_flush; e.rpc = v.exp_rpc;
    sb_q.push_back(e);
    tick();
    if_valid_i = 1'b0;
    tick();
    ex_br_sel_i = v.br_sel; ex_target_i = v.ex_tgt;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check($sformatf("v%0d scoreboard_empty", id), 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("v%0d flush", got.id), {31'd0, flush_o}, {31'd0, got.flush});
      check($sformatf("v%0d redirect", got.id), {31'd0, redirect_o}, {31'd0, got.flush});
      if (got.valid) begin
        check($sformatf("v%0d redirect_pc", got.id), redirect_pc_o, got.rpc);
      end
    end
    if (v.valid) begin
      if (v.is_br) begin
        m_br++;
        m_bht[v.pc[5:2]] = pipeline_pkg::ctr_update(m_bht[v.pc[5:2]], v.br_sel);
      end
      if (v.exp_flush) m_mis++;
    end
    tick();
    ex_br_sel_i = 1'b0;
    check_state($sformatf("v%0d", id));
    $display("vec %0d pc=0x%08h flush=%0b rpc=0x%08h br_cnt=%0d mis=%0d",
             id, v.pc, v.exp_flush, v.exp_rpc, br_cnt_o, mispred_cnt_o);
  endtask

  initial begin
    logic [31:0] b_p16;
    logic [31:0] b_m4;
    logic [31:0] j_m8;
    b_p16 = enc_b(13'h0010);
    b_m4  = enc_b(13'h1FFC);
    j_m8  = enc_j(21'h1FFFF8);

    vecs[0]  = mk(1, 32'h100, b_p16, 1, 32'h110, 1, 0, 32'h110, 1, 32'h110);
    vecs[1]  = mk(1, 32'h100, b_p16, 1, 32'h110, 1, 1, 32'h110, 0, 32'h104);
    vecs[2]  = mk(1, 32'h100, b_p16, 1, 32'h110, 1, 1, 32'h110, 0, 32'h104);
    vecs[3]  = mk(1, 32'h100, b_p16, 0, 32'h000, 1, 1, 32'h110, 1, 32'h104);
    vecs[4]  = mk(1, 32'h200, j_m8,  1, 32'h1F8, 0, 1, 32'h1F8, 0, 32'h204);
    vecs[5]  = mk(1, 32'h300, 32'h000000E7, 1, 32'h400, 0, 0, 32'h304, 1, 32'h400);
    vecs[6]  = mk(1, 32'h400, 32'h00000013, 1, 32'h999, 0, 0, 32'h404, 0, 32'h404);
    vecs[7]  = mk(1, 32'h104, b_m4,  0, 32'h000, 1, 0, 32'h100, 0, 32'h108);
    vecs[8]  = mk(1, 32'h104, b_m4,  0, 32'h000, 1, 0, 32'h100, 0, 32'h108);
    vecs[9]  = mk(1, 32'h104, b_m4,  1, 32'h100, 1, 0, 32'h100, 1, 32'h100);
    vecs[10] = mk(1, 32'h100, b_p16, 1, 32'h120, 1, 1, 32'h110, 1, 32'h120);
    vecs[11] = mk(0, 32'h100, b_p16, 1, 32'h110, 1, 0, 32'h104, 0, 32'h104);

    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;

    rst_i = 1'b1; stall_i = 1'b0; if_valid_i = 1'b0; if_pc_i = 32'd0;
    if_instr_i = 32'd0; ex_br_sel_i = 1'b0; ex_target_i = 32'd0;
    tick(); tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("reset flush", {31'd0, flush_o}, 32'd0);
    check_state("reset");
    tick();

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Stall with a mispredicting branch (bht[0]=3 predicts taken) in EX.
    if_valid_i = 1'b1; if_pc_i = 32'h100; if_instr_i = b_p16;
    @(negedge clk);
    check("stall pred_taken", {31'd0, pred_taken_o}, 32'd1);
    tick();
    if_valid_i = 1'b0;
    tick();
    stall_i = 1'b1; ex_br_sel_i = 1'b0; ex_target_i = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall c%0d flush", c), {31'd0, flush_o}, 32'd0);
      check($sformatf("stall c%0d redirect", c), {31'd0, redirect_o}, 32'd0);
      tick();
      check_state($sformatf("stall c%0d", c));
    end
    stall_i = 1'b0;
    @(negedge clk);
    check("unstall flush", {31'd0, flush_o}, 32'd1);
    check("unstall redirect", {31'd0, redirect_o}, 32'd1);
    check("unstall redirect_pc", redirect_pc_o, 32'h104);
    m_br++; m_mis++;
    m_bht[0] = pipeline_pkg::ctr_update(m_bht[0], 1'b0);
    tick();
    check_state("unstall");
    $display("stall seq: br_cnt=%0d mis=%0d", br_cnt_o, mispred_cnt_o);

    // Reset while a mispredicting branch sits in ID.
    if_valid_i = 1'b1; if_pc_i = 32'h104; if_instr_i = b_m4;
    tick();
    if_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    ex_br_sel_i = 1'b1; ex_target_i = 32'h100;
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_br = 0; m_mis = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post-reset c%0d flush", c), {31'd0, flush_o}, 32'd0);
      tick();
    end
    check_state("post-reset");
    $display("reset seq: br_cnt=%0d mis=%0d", br_cnt_o, mispred_cnt_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a runaway simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_ctrl_pipeline.md
Name: branch_ctrl_pipeline

Overview:
Branch prediction and redirect controller for the 5-stage RV32I pipeline.
- Predicts B-type branches (2-bit BHT) and JAL (always taken) in IF, computing the predicted target from the fetched instruction.
- Carries prediction metadata through ID to EX.
- In EX, compares the prediction with the resolved outcome from the branch comparator (br_sel) and issues a one-cycle flush plus redirect PC on mispredict.
- Maintains branch and mispredict performance counters.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters; power of 2, at least 2.
- IDX_W, $clog2(BHT_ENTRIES), BHT index width; indexed by pc[IDX_W+1:2].

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous reset, active-high
- stall_i  input  1  freezes the IF/ID and ID/EX metadata registers; suppresses EX resolution
- if_valid_i  input  1  IF holds a valid instruction
- if_pc_i  input  32  IF PC
- if_instr_i  input  32  IF instruction
- pred_taken_o  output  1  IF prediction (combinational)
- pred_target_o  output  32  IF predicted target (combinational)
- ex_br_sel_i  input  1  resolved taken, from the branch comparator
- ex_target_i  input  32  resolved target (ALU result) for a taken branch or jump
- flush_o  output  1  kill IF/ID and ID/EX
- redirect_o  output  1  load redirect_pc_o into the PC
- redirect_pc_o  output  32  corrected fetch PC
- br_cnt_o  output  32  resolved B-type count
- mispred_cnt_o  output  32  mispredict count

Behaviour:
Instruction classes (by instr[6:2]):
- 11000 is B-type.
- 11011 is JAL.
- 11001 is JALR.
- All other opcodes are non-control.

IF prediction (combinational):
- B-type: pred_taken_o = bht[idx][1]; target = pc + sext B-immediate.
- JAL: pred_taken_o = 1; target = pc + sext J-immediate.
- JALR, non-control, or if_valid_i = 0: pred_taken_o = 0; pred_target_o = pc + 4.

Metadata pipe:
- Fields {valid, pc, class, pred_taken, pred_target} are registered IF to ID to EX.
- When stall_i = 1, both stages hold.
- When flush_o = 1, both stage valids clear on the next edge; flush has priority over stall.

EX resolution (combinational, when ex.valid && !stall_i):
- taken = ex_br_sel_i for B, JAL and JALR; forced to 0 for non-control.
- mispredict = (taken != pred_taken) or (taken && ex_target_i != pred_target).
- On mispredict: flush_o = redirect_o = 1; redirect_pc_o = taken ? ex_target_i : ex.pc + 4.
- Otherwise: flush_o = redirect_o = 0; redirect_pc_o = ex.pc + 4 (don't-care).
- JALR always mispredicts. Non-control instructions never redirect.

BHT update (next edge, resolving B-type only):
- Counter saturates at 0 and 3: +1 if taken, -1 if not taken.
- No write-to-read bypass: an IF read of the same index in the same cycle sees the old value.

Performance counters (next edge, on resolution):
- br_cnt increments per resolved B-type.
- mispred_cnt increments per mispredict of any class.
- Both wrap at 2^32.

Reset (synchronous):
- All BHT entries = 2'b01 (weakly not-taken).
- Metadata valids = 0.
- Counters = 0.
- flush_o / redirect_o = 0 from the first cycle after reset, since EX valid = 0.
- Reset mid-operation discards any in-flight metadata; the BHT is re-initialised.

Stall with a mispredict pending in EX:
- No redirect, no BHT or counter update.
- Resolution happens in the first non-stalled cycle.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - Opcode constants OP_BRANCH = 5'b11000, OP_JAL = 5'b11011, OP_JALR = 5'b11001.
  - br_class_e enum {CLS_NONE, CLS_BR, CLS_JAL, CLS_JALR}.
  - br_meta_t struct {valid, pc, cls, pred_taken, pred_target}.
- One sub-module, bht_2bit (parameterised counter array with combinational read and synchronous update/reset), instantiated once.
- Immediate decode stays inline.

Test Plan:
1. Reset, then B-type at pc=0x100, imm=+16, ex_br_sel_i=1, ex_target_i=0x110. Required: pred_taken_o=0; in EX flush_o=redirect_o=1, redirect_pc_o=0x110; bht[0] becomes 2; br_cnt=1, mispred_cnt=1.
2. Same branch resolved taken twice more. Required: counter reaches 3 and saturates; the third fetch shows pred_taken_o=1, pred_target_o=0x110 with no redirect; then resolving not-taken gives redirect_pc_o=0x104 and counter=2.
3. JAL at pc=0x200, imm=-8, ex_target_i=0x1F8. Required: pred_target_o=0x1F8; no flush; br_cnt unchanged.
4. JALR at pc=0x300, ex_target_i=0x400. Required: redirect_pc_o=0x400, flush_o=1, mispred_cnt increments.
5. Mispredicting branch in EX with stall_i=1 for 3 cycles. Required: flush_o=0 and counters/BHT unchanged during the stall; flush and redirect fire in the cycle stall_i drops.
6. rst_i asserted while a mispredict is in ID. Required: flush_o stays 0 for the following cycles; all BHT entries read 2'b01; counters are 0.
